// File: rtl/vram_arbiter_pkg.sv
// vram_arbiter_pkg
//   Shared VRAM geometry and arbiter state encoding.
//   VRAM_DATA_W : VRAM row width (bits)
//   VRAM_ADDR_W : VRAM row address width
//   VRAM_RD_LAT : VRAM read latency, address presented -> dout valid
package vram_arbiter_pkg;

  localparam int VRAM_DATA_W = 640;
  localparam int VRAM_ADDR_W = 9;
  localparam int VRAM_RD_LAT = 1;

  // IDLE: nobody owns the port. BUSY: r_owner holds it, r_beat_cnt beats so far.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_e;

endpackage

// File: rtl/vram_rr_pick.sv
// vram_rr_pick
//   Combinational rotating-priority picker. Searches i_req starting at
//   i_start and wrapping upward; the first set bit wins.
//   i_req   : request vector
//   i_start : index with highest priority
//   o_gnt   : one-hot winner (zero if no request)
//   o_idx   : index of the winner
//   o_any   : at least one request present
module vram_rr_pick #(
  parameter int NREQ = 2,
  parameter int IDXW = 1
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IDXW-1:0] i_start,
  output logic [NREQ-1:0] o_gnt,
  output logic [IDXW-1:0] o_idx,
  output logic            o_any
);

  localparam int IW1 = IDXW + 1;

  logic [IW1-1:0] w_pos;

  // Walk from the farthest position back to i_start so the nearest
  // requester (smallest rotation distance) is the last one written.
  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    w_pos = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_pos = {1'b0, i_start} + IW1'(k);
      if (w_pos >= IW1'(NREQ)) w_pos = w_pos - IW1'(NREQ);
      if (i_req[w_pos[IDXW-1:0]]) begin
        o_gnt                   = '0;
        o_gnt[w_pos[IDXW-1:0]]  = 1'b1;
        o_idx                   = w_pos[IDXW-1:0];
        o_any                   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter
//   Work-conserving round-robin arbiter sharing the single-port VRAM among
//   NREQ requesters, with bounded bursts and tagged read-data return.
//   i_clk / i_rst       : clock, synchronous active-high reset
//   i_req / i_we        : per-requester beat request and type (1 = write)
//   i_addr / i_wdata    : flattened per-requester address / write data
//   o_gnt               : one-hot/zero grant, combinational
//   o_rd_valid          : one-hot/zero owner of o_rd_data this cycle
//   o_rd_data           : shared read-return bus
//   o_owner             : current/last grant holder
//   o_to_vram_*         : registered VRAM address, write data, write enable
//   i_from_vram_read    : VRAM dout
module vram_arbiter
  import vram_arbiter_pkg::*;
#(
  parameter int NREQ      = 2,
  parameter int DATA_W    = VRAM_DATA_W,
  parameter int ADDR_W    = VRAM_ADDR_W,
  parameter int RD_LAT    = VRAM_RD_LAT,
  parameter int MAX_BURST = 4
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [NREQ-1:0]           i_req,
  input  logic [NREQ-1:0]           i_we,
  input  logic [NREQ*ADDR_W-1:0]    i_addr,
  input  logic [NREQ*DATA_W-1:0]    i_wdata,
  output logic [NREQ-1:0]           o_gnt,
  output logic [NREQ-1:0]           o_rd_valid,
  output logic [DATA_W-1:0]         o_rd_data,
  output logic [$clog2(NREQ)-1:0]   o_owner,
  output logic [ADDR_W-1:0]         o_to_vram_addr,
  output logic [DATA_W-1:0]         o_to_vram_write,
  output logic                      o_to_vram_wea,
  input  logic [DATA_W-1:0]         i_from_vram_read
);

  localparam int IDXW = $clog2(NREQ);
  localparam int BCW  = $clog2(MAX_BURST + 1);

  arb_state_e        r_state, w_nstate;
  logic [IDXW-1:0]   r_owner, w_nowner;
  logic [IDXW-1:0]   r_rr_ptr, w_nrr;
  logic [BCW-1:0]    r_beat_cnt, w_ncnt;

  logic [ADDR_W-1:0] r_to_vram_addr;
  logic [DATA_W-1:0] r_to_vram_write;
  logic              r_to_vram_wea;

  // Read tag pipeline: stage k holds a read accepted k+1 cycles ago.
  logic [RD_LAT:0]   r_vld_pipe;
  logic [IDXW-1:0]   r_id_pipe [RD_LAT:0];

  logic [NREQ-1:0]   w_gnt;
  logic [IDXW-1:0]   w_owner_inc;
  logic [IDXW-1:0]   w_start;
  logic [NREQ-1:0]   w_pick_gnt;
  logic [IDXW-1:0]   w_pick_idx;
  logic              w_pick_any;
  logic              w_acc;
  logic              w_we_sel;

  logic [ADDR_W-1:0] w_addr_a  [NREQ];
  logic [DATA_W-1:0] w_wdata_a [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign w_addr_a[g]  = i_addr[g*ADDR_W +: ADDR_W];
    assign w_wdata_a[g] = i_wdata[g*DATA_W +: DATA_W];
  end

  assign w_owner_inc = (r_owner == IDXW'(NREQ - 1)) ? '0 : r_owner + IDXW'(1);

  // On handover the search starts just past the releasing owner, so the
  // owner itself is considered last (lets a lone requester re-win at once).
  assign w_start = (r_state == ST_BUSY) ? w_owner_inc : r_rr_ptr;

  vram_rr_pick #(
    .NREQ (NREQ),
    .IDXW (IDXW)
  ) u_pick (
    .i_req   (i_req),
    .i_start (w_start),
    .o_gnt   (w_pick_gnt),
    .o_idx   (w_pick_idx),
    .o_any   (w_pick_any)
  );

  always_comb begin
    w_gnt    = '0;
    w_nstate = r_state;
    w_nowner = r_owner;
    w_nrr    = r_rr_ptr;
    w_ncnt   = r_beat_cnt;
    unique case (r_state)
      ST_IDLE: begin
        if (w_pick_any) begin
          w_gnt    = w_pick_gnt;
          w_nstate = ST_BUSY;
          w_nowner = w_pick_idx;
          w_ncnt   = BCW'(1);
        end
      end
      ST_BUSY: begin
        if (i_req[r_owner] && (r_beat_cnt < BCW'(MAX_BURST))) begin
          w_gnt[r_owner] = 1'b1;
          w_ncnt         = r_beat_cnt + BCW'(1);
        end else begin
          w_nrr = w_owner_inc;
          if (w_pick_any) begin
            w_gnt    = w_pick_gnt;
            w_nowner = w_pick_idx;
            w_ncnt   = BCW'(1);
          end else begin
            w_nstate = ST_IDLE;
          end
        end
      end
      default: w_nstate = ST_IDLE;
    endcase
    if (i_rst) w_gnt = '0;
  end

  assign w_acc    = |w_gnt;
  assign w_we_sel = i_we[w_nowner];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state         <= ST_IDLE;
      r_owner         <= '0;
      r_rr_ptr        <= '0;
      r_beat_cnt      <= '0;
      r_to_vram_addr  <= '0;
      r_to_vram_write <= '0;
      r_to_vram_wea   <= 1'b0;
      r_vld_pipe      <= '0;
    end else begin
      r_state       <= w_nstate;
      r_owner       <= w_nowner;
      r_rr_ptr      <= w_nrr;
      r_beat_cnt    <= w_ncnt;
      r_to_vram_wea <= w_acc & w_we_sel;
      if (w_acc) begin
        r_to_vram_addr  <= w_addr_a[w_nowner];
        r_to_vram_write <= w_wdata_a[w_nowner];
      end
      r_vld_pipe <= {r_vld_pipe[RD_LAT-1:0], w_acc & ~w_we_sel};
    end
  end

  // Tags only matter where the matching valid bit is set; no reset needed.
  always_ff @(posedge i_clk) begin
    r_id_pipe[0] <= w_nowner;
    for (int k = 1; k <= RD_LAT; k++) r_id_pipe[k] <= r_id_pipe[k-1];
  end

  always_comb begin
    o_rd_valid = '0;
    if (r_vld_pipe[RD_LAT]) o_rd_valid[r_id_pipe[RD_LAT]] = 1'b1;
  end

  assign o_gnt           = w_gnt;
  assign o_rd_data       = i_from_vram_read;
  assign o_owner         = r_owner;
  assign o_to_vram_addr  = r_to_vram_addr;
  assign o_to_vram_write = r_to_vram_write;
  assign o_to_vram_wea   = r_to_vram_wea;

endmodule

// File: tb/tb_vram_arbiter.sv
module tb_vram_arbiter;

  localparam int NREQ = 2;
  localparam int DW   = 640;
  localparam int AW   = 9;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [NREQ-1:0]    req = '0;
  logic [NREQ-1:0]    we  = '0;
  logic [NREQ*AW-1:0] addr = '0;
  logic [NREQ*DW-1:0] wdata = '0;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    rd_valid;
  logic [DW-1:0]      rd_data;
  logic [0:0]         owner;
  logic [AW-1:0]      v_addr;
  logic [DW-1:0]      v_write;
  logic               v_wea;
  logic [DW-1:0]      v_read = '0;

  always #5 clk = ~clk;

  vram_arbiter #(
    .NREQ(NREQ), .DATA_W(DW), .ADDR_W(AW), .RD_LAT(1), .MAX_BURST(4)
  ) dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_req            (req),
    .i_we             (we),
    .i_addr           (addr),
    .i_wdata          (wdata),
    .o_gnt            (gnt),
    .o_rd_valid       (rd_valid),
    .o_rd_data        (rd_data),
    .o_owner          (owner),
    .o_to_vram_addr   (v_addr),
    .o_to_vram_write  (v_write),
    .o_to_vram_wea    (v_wea),
    .i_from_vram_read (v_read)
  );

  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
    return {20{32'hA5A5_0000 | {23'h0, a}}};
  endfunction

  function automatic logic [DW-1:0] wpat(input logic [AW-1:0] a);
    return {20{32'hD00D_0000 | {23'h0, a}}};
  endfunction

  // VRAM model: one-cycle registered read, read-before-write.
  logic [DW-1:0] mem [512];
  initial for (int i = 0; i < 512; i++) mem[i] = pat(AW'(i));
  always @(posedge clk) begin
    if (v_wea) mem[v_addr] <= v_write;
    v_read <= mem[v_addr];
  end

  typedef struct { logic [1:0] gnt; logic wea; } gexp_t;
  typedef struct { int id; int due; logic [DW-1:0] data; } rexp_t;
  typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } wexp_t;

  gexp_t gq[$];
  rexp_t rq[$];
  wexp_t wq[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit mon_on = 1'b0;
  bit exp_wea = 1'b0;
  bit wea_nxt;
  gexp_t gm;
  rexp_t rm;
  wexp_t wm;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d: got %0h want %0h", nm, cyc, act, exp);
    end
  endtask

  // Monitor: compares every cycle against what the stimulus queued.
  always @(negedge clk) if (mon_on) begin
    if (gq.size() > 0) begin
      gm = gq.pop_front();
      chk("gnt", DW'(gnt), DW'(gm.gnt));
      wea_nxt = gm.wea;
    end else begin
      wea_nxt = 1'b0;
    end
    chk("wea", DW'(v_wea), DW'(exp_wea));
    exp_wea = wea_nxt;
    if (v_wea) begin
      if (wq.size() > 0) begin
        wm = wq.pop_front();
        chk("wr_addr", DW'(v_addr), DW'(wm.a));
        chk("wr_data", v_write, wm.d);
      end else chk("wr_unexpected", DW'(1), DW'(0));
    end
    if (rd_valid != '0) begin
      if (rq.size() > 0) begin
        rm = rq.pop_front();
        chk("rd_valid", DW'(rd_valid), DW'(2'b01 << rm.id));
        chk("rd_data", rd_data, rm.data);
        chk("rd_cycle", DW'(cyc), DW'(rm.due));
      end else chk("rd_unexpected", DW'(rd_valid), DW'(0));
    end else if (rq.size() > 0 && rq[0].due <= cyc) begin
      rm = rq.pop_front();
      chk("rd_missing", DW'(0), DW'(1));
    end
  end

  task automatic step(input logic r, input logic [1:0] rq_, input logic [1:0] we_,
                      input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic [1:0] eg);
    logic [AW-1:0] aa [2];
    aa[0] = a0; aa[1] = a1;
    @(posedge clk); #1;
    rst   = r;
    req   = rq_;
    we    = we_;
    addr  = {a1, a0};
    wdata = {wpat(a1), wpat(a0)};
    mon_on = 1'b1;
    // Reads still in flight when reset lands must never come back.
    if (r) while (rq.size() > 0 && rq[rq.size()-1].due > cyc) void'(rq.pop_back());
    gq.push_back('{gnt: eg, wea: |(eg & we_)});
    for (int i = 0; i < 2; i++) if (eg[i]) begin
      if (we_[i]) wq.push_back('{a: aa[i], d: wpat(aa[i])});
      else        rq.push_back('{id: i, due: cyc + 2, data: pat(aa[i])});
    end
  endtask

  initial begin
    // 1: reset held with both requesting
    for (int i = 0; i < 3; i++) step(1'b1, 2'b11, 2'b00, 9'h010, 9'h020, 2'b00);
    chk("owner_rst", DW'(owner), DW'(0));
    // 2: both requesting reads, bursts of 4, no idle cycle
    step(0, 2'b11, 2'b00, 9'h010, 9'h020, 2'b01);
    step(0, 2'b11, 2'b00, 9'h010, 9'h020, 2'b01);
    step(0, 2'b11, 2'b00, 9'h010, 9'h020, 2'b01);
    step(0, 2'b11, 2'b00, 9'h010, 9'h020, 2'b01);
    step(0, 2'b11, 2'b00, 9'h010, 9'h020, 2'b10);
    step(0, 2'b11, 2'b00, 9'h010, 9'h020, 2'b10);
    step(0, 2'b11, 2'b00, 9'h010, 9'h020, 2'b10);
    step(0, 2'b11, 2'b00, 9'h010, 9'h020, 2'b10);
    step(0, 2'b11, 2'b00, 9'h010, 9'h020, 2'b01);
    step(0, 2'b11, 2'b00, 9'h010, 9'h020, 2'b01);
    // 3: lone requester 1 writing, re-granted across burst limit
    for (int i = 0; i < 10; i++) step(0, 2'b10, 2'b10, 9'h000, 9'h100, 2'b10);
    chk("owner_lone", DW'(owner), DW'(1));
    // 4: read row 5 from req0, then write 1FF from req1
    step(0, 2'b01, 2'b00, 9'h005, 9'h1FF, 2'b01);
    step(0, 2'b10, 2'b10, 9'h005, 9'h1FF, 2'b10);
    // 5: req0 drops mid-burst while req1 waits
    step(0, 2'b01, 2'b10, 9'h007, 9'h0AA, 2'b01);
    step(0, 2'b11, 2'b10, 9'h007, 9'h0AA, 2'b01);
    step(0, 2'b10, 2'b10, 9'h007, 9'h0AA, 2'b10);
    // 6: read accepted, then reset: no return, arbitration restarts at 0
    step(0, 2'b01, 2'b00, 9'h009, 9'h0AA, 2'b01);
    step(1, 2'b11, 2'b00, 9'h009, 9'h0AA, 2'b00);
    step(1, 2'b11, 2'b00, 9'h009, 9'h0AA, 2'b00);
    chk("owner_rst2", DW'(owner), DW'(0));
    step(0, 2'b11, 2'b00, 9'h00B, 9'h00C, 2'b01);
    step(0, 2'b10, 2'b00, 9'h00B, 9'h00C, 2'b10);
    for (int i = 0; i < 4; i++) step(0, 2'b00, 2'b00, 9'h000, 9'h000, 2'b00);
    @(negedge clk); #1;
    chk("gq_drained", DW'(gq.size()), DW'(0));
    chk("rq_drained", DW'(rq.size()), DW'(0));
    chk("wq_drained", DW'(wq.size()), DW'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
